systolic_ofmap_collector: RTL and testbench

SYSTOLIC_OFMAP_COLLECTOR -- requirements
Module: systolic_ofmap_collector

---
 rtl/systolic_pkg.sv | 14 +
 rtl/collector_fifo.sv | 55 +++++
 rtl/systolic_ofmap_collector.sv | 173 +++++++++++++++++
 tb/tb_systolic_ofmap_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state encoding for the systolic-array output collector.
package systolic_pkg;

  localparam int AK_BW_DEF  = 20;
  localparam int COLS_DEF   = 5;
  localparam int ACC_BW_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ACCUM   = 2'd2
  } state_e;

endpackage

// File: rtl/collector_fifo.sv
// Output-vector FIFO: power-of-2 depth, registered occupancy, head presented combinationally.
module collector_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = i_push && (cnt_q < CNT_W'(DEPTH));
  assign do_pop  = i_pop && (cnt_q != '0);

  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is gated by occupancy so stale words never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_cnt  = cnt_q;

endmodule

// File: rtl/systolic_ofmap_collector.sv
// Collects skewed column sums, accumulates num_pass passes with saturation, queues output vectors.
// Define COLLECTOR_RELU_EN to clamp negative lanes to zero as each vector is pushed.
module systolic_ofmap_collector
  import systolic_pkg::*;
#(
  parameter int AK_BW      = AK_BW_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int ACC_BW     = ACC_BW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [3:0]                    i_num_pass,
  input  logic                          i_clear,
  input  logic [AK_BW*COLS-1:0]         i_acc_kernel,
  input  logic [COLS-1:0]               i_col_vld,
  output logic [ACC_BW*COLS-1:0]        o_ofmap,
  output logic                          o_vld,
  input  logic                          i_rdy,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int VEC_W = ACC_BW * COLS;

  state_e             state_q, state_d;
  logic [COLS-1:0]    mask_q, mask_d;
  logic [3:0]         pass_cnt_q, pass_cnt_d;
  logic [3:0]         num_pass_q, num_pass_d;
  logic [VEC_W-1:0]   acc_q, acc_d;
  logic [VEC_W-1:0]   cap_q, cap_d;
  logic               err_q, err_d;
  logic               push_q, push_d;
  logic [VEC_W-1:0]   push_data_q, push_data_d;

  logic [VEC_W-1:0]   cap_ext, sum_flat, push_flat;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               final_pass, room;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic signed [AK_BW-1:0] ak;
    logic [ACC_BW-1:0]       acc_l, cap_l, sat;
    logic [ACC_BW:0]         wide;

    assign ak    = i_acc_kernel[c*AK_BW +: AK_BW];
    assign acc_l = acc_q[c*ACC_BW +: ACC_BW];
    assign cap_l = cap_q[c*ACC_BW +: ACC_BW];
    assign cap_ext[c*ACC_BW +: ACC_BW] = ACC_BW'(ak);
    assign wide  = {acc_l[ACC_BW-1], acc_l} + {cap_l[ACC_BW-1], cap_l};
    // Disagreeing top two bits mean overflow; clamp toward the sign of the true result.
    assign sat   = (wide[ACC_BW] != wide[ACC_BW-1])
                 ? {wide[ACC_BW], {(ACC_BW-1){~wide[ACC_BW]}}}
                 : wide[ACC_BW-1:0];
    assign sum_flat[c*ACC_BW +: ACC_BW] = sat;
`ifdef COLLECTOR_RELU_EN
    assign push_flat[c*ACC_BW +: ACC_BW] = sat[ACC_BW-1] ? '0 : sat;
`else
    assign push_flat[c*ACC_BW +: ACC_BW] = sat;
`endif
  end

  assign final_pass = (pass_cnt_q == num_pass_q - 4'd1);
  // The vector still in the push stage already owns a slot; a same-cycle pop is not counted.
  assign room = (fifo_cnt + CNT_W'(push_q)) < CNT_W'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pass_cnt_d  = pass_cnt_q;
    num_pass_d  = num_pass_q;
    acc_d       = acc_q;
    cap_d       = cap_q;
    err_d       = err_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_COLLECT;
          num_pass_d = (i_num_pass == 4'd0) ? 4'd1 : i_num_pass;
        end
      end
      ST_COLLECT: begin
        for (int c = 0; c < COLS; c++) begin
          if (i_col_vld[c]) begin
            if (mask_q[c]) begin
              err_d = 1'b1;
            end else begin
              cap_d[c*ACC_BW +: ACC_BW] = cap_ext[c*ACC_BW +: ACC_BW];
              mask_d[c] = 1'b1;
            end
          end
        end
        if (&mask_d) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        mask_d = '0;
        if (!final_pass) begin
          acc_d      = sum_flat;
          pass_cnt_d = pass_cnt_q + 4'd1;
          state_d    = ST_COLLECT;
        end else if (room) begin
          push_d      = 1'b1;
          push_data_d = push_flat;
          acc_d       = '0;
          pass_cnt_d  = '0;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_COLLECT) && (|i_col_vld)) err_d = 1'b1;

    if (i_clear) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      mask_d      = '0;
      pass_cnt_d  = '0;
      cap_d       = cap_q;
      err_d       = err_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      pass_cnt_q  <= '0;
      num_pass_q  <= '0;
      acc_q       <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pass_cnt_q  <= pass_cnt_d;
      num_pass_q  <= num_pass_d;
      acc_q       <= acc_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  collector_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (push_q),
    .i_data (push_data_q),
    .i_pop  (i_rdy),
    .o_data (o_ofmap),
    .o_cnt  (fifo_cnt)
  );

  assign o_vld      = (fifo_cnt != '0);
  assign o_fifo_cnt = fifo_cnt;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_systolic_ofmap_collector.sv
// Directed bench for systolic_ofmap_collector: default instance plus an ACC_BW=20 instance for saturation.
module tb_systolic_ofmap_collector;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [3:0]   i_num_pass;
  logic         i_clear;
  logic [99:0]  i_acc_kernel;
  logic [4:0]   i_col_vld;
  logic         i_rdy;

  logic [119:0] o_ofmap;
  logic         o_vld, o_busy, o_err;
  logic [2:0]   o_fifo_cnt;

  logic [99:0]  s_ofmap;
  logic         s_vld, s_busy, s_err;
  logic [2:0]   s_fifo_cnt;

  int n_checks = 0;
  int n_errors = 0;

  systolic_ofmap_collector dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
    .i_clear(i_clear), .i_acc_kernel(i_acc_kernel), .i_col_vld(i_col_vld),
    .o_ofmap(o_ofmap), .o_vld(o_vld), .i_rdy(i_rdy), .o_busy(o_busy),
    .o_err(o_err), .o_fifo_cnt(o_fifo_cnt)
  );

  systolic_ofmap_collector #(.ACC_BW(20)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
    .i_clear(i_clear), .i_acc_kernel(i_acc_kernel), .i_col_vld(i_col_vld),
    .o_ofmap(s_ofmap), .o_vld(s_vld), .i_rdy(i_rdy), .o_busy(s_busy),
    .o_err(s_err), .o_fifo_cnt(s_fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [19:0] v);
    for (int c = 0; c < 5; c++) i_acc_kernel[c*20 +: 20] = v;
  endtask

  task automatic capture_all(input logic [19:0] v);
    set_all(v);
    i_col_vld = 5'h1F;
    tick();
    i_col_vld = 5'h00;
  endtask

  task automatic start_job(input logic [3:0] np);
    i_num_pass = np;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic clear_job();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic pop1();
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
  endtask

  function automatic logic [119:0] rep24(input logic [23:0] v);
    return {5{v}};
  endfunction

  function automatic logic [99:0] rep20(input logic [19:0] v);
    return {5{v}};
  endfunction

  logic [23:0] neg21_exp;
  logic [19:0] neg21_exp_s;

  initial begin
`ifdef COLLECTOR_RELU_EN
    neg21_exp   = 24'h0;
    neg21_exp_s = 20'h0;
`else
    neg21_exp   = 24'hFFFFEB;
    neg21_exp_s = 20'hFFFEB;
`endif
    rst_n = 1'b0; i_start = 1'b0; i_num_pass = 4'd1; i_clear = 1'b0;
    i_acc_kernel = '0; i_col_vld = '0; i_rdy = 1'b0;
    #1;
    check("rst_vld", o_vld, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt", o_fifo_cnt, 0);
    check("rst_ofmap", o_ofmap, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single pass, columns skewed one cycle apart, values 1..5.
    start_job(4'd1);
    check("sp_busy", o_busy, 1);
    for (int c = 0; c < 5; c++) begin
      i_col_vld = 5'(1 << c);
      i_acc_kernel[c*20 +: 20] = 20'(c + 1);
      tick();
    end
    i_col_vld = '0;
    check("sp_lat0", o_vld, 0);
    tick();
    check("sp_lat1", o_vld, 0);
    tick();
    check("sp_lat2", o_vld, 1);
    check("sp_ofmap", o_ofmap, {24'd5, 24'd4, 24'd3, 24'd2, 24'd1});
    check("sp_cnt", o_fifo_cnt, 1);
    check("sp_err", o_err, 0);
    pop1();
    check("sp_pop_cnt", o_fifo_cnt, 0);

    // Three passes of -7 on every lane, all columns valid together.
    clear_job();
    check("clr_busy", o_busy, 0);
    start_job(4'd3);
    for (int p = 0; p < 3; p++) begin
      capture_all(20'hFFFF9);
      tick();
    end
    check("mp_lat1", o_vld, 0);
    tick();
    check("mp_vld", o_vld, 1);
    check("mp_ofmap", o_ofmap, rep24(neg21_exp));
    check("mp_ofmap_s", s_ofmap, rep20(neg21_exp_s));
    pop1();

    // Saturation: 0x7FFFF twice; fits in 24 bits, clamps in 20 bits.
    clear_job();
    start_job(4'd2);
    for (int p = 0; p < 2; p++) begin
      capture_all(20'h7FFFF);
      tick();
    end
    tick();
    check("sat_vld", s_vld, 1);
    check("sat_ofmap24", o_ofmap, rep24(24'h0FFFFE));
    check("sat_ofmap20", s_ofmap, rep20(20'h7FFFF));
    pop1();

    // Backpressure: five single-pass vectors with i_rdy low.
    clear_job();
    start_job(4'd1);
    for (int k = 0; k < 5; k++) begin
      capture_all(20'(k + 11));
      tick();
    end
    check("bp_cnt_full", o_fifo_cnt, 4);
    tick(); tick();
    check("bp_cnt_hold", o_fifo_cnt, 4);
    check("bp_busy", o_busy, 1);
    check("bp_head", o_ofmap, rep24(24'd11));
    pop1();
    check("bp_cnt_pop", o_fifo_cnt, 3);
    tick();
    check("bp_cnt_stage", o_fifo_cnt, 3);
    tick();
    check("bp_cnt_refill", o_fifo_cnt, 4);
    i_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_drain%0d", j), o_ofmap, rep24(24'(12 + j)));
      tick();
    end
    i_rdy = 1'b0;
    check("bp_empty", o_vld, 0);
    check("bp_err", o_err, 0);

    // Overrun: col2 valid twice before the mask completes.
    clear_job();
    start_job(4'd1);
    i_acc_kernel[40 +: 20] = 20'd9;
    i_col_vld = 5'b00100;
    tick();
    check("ov_err0", o_err, 0);
    i_acc_kernel[40 +: 20] = 20'd77;
    tick();
    check("ov_err1", o_err, 1);
    i_acc_kernel[0 +: 20]  = 20'd1;
    i_acc_kernel[20 +: 20] = 20'd2;
    i_acc_kernel[60 +: 20] = 20'd4;
    i_acc_kernel[80 +: 20] = 20'd5;
    i_col_vld = 5'b11011;
    tick();
    i_col_vld = '0;
    tick(); tick();
    check("ov_ofmap", o_ofmap, {24'd5, 24'd4, 24'd9, 24'd2, 24'd1});
    pop1();

    // Abort mid-pass keeps FIFO and err, clears mask/acc.
    capture_all(20'd3);
    tick(); tick();
    check("ab_cnt0", o_fifo_cnt, 1);
    i_acc_kernel[0 +: 20] = 20'd8;
    i_col_vld = 5'b00001;
    tick();
    i_col_vld = '0;
    clear_job();
    check("ab_busy", o_busy, 0);
    check("ab_cnt", o_fifo_cnt, 1);
    check("ab_head", o_ofmap, rep24(24'd3));
    check("ab_err", o_err, 1);
    start_job(4'd1);
    capture_all(20'd6);
    tick(); tick();
    check("ab_cnt2", o_fifo_cnt, 2);
    pop1();
    check("ab_new", o_ofmap, rep24(24'd6));

    // Reset asserted mid-ACCUM clears every output without a clock edge.
    capture_all(20'd2);
    rst_n = 1'b0;
    #1;
    check("ar_vld", o_vld, 0);
    check("ar_busy", o_busy, 0);
    check("ar_err", o_err, 0);
    check("ar_cnt", o_fifo_cnt, 0);
    check("ar_ofmap", o_ofmap, 0);
    check("ar_ofmap_s", s_ofmap, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // num_pass of 0 behaves as a single pass.
    start_job(4'd0);
    capture_all(20'd4);
    tick(); tick();
    check("np0_cnt", o_fifo_cnt, 1);
    check("np0_ofmap", o_ofmap, rep24(24'd4));

    // A column valid while IDLE raises the sticky error.
    clear_job();
    check("idle_err0", o_err, 0);
    i_col_vld = 5'b10000;
    tick();
    i_col_vld = '0;
    check("idle_err1", o_err, 1);
    check("idle_cnt", o_fifo_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
